ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits between `ps2_if` and `TETRIS_GAME`.
- Drains the `ps2_if` byte FIFO and parses PS/2 set-2 prefixes (E0 extended, F0 break, E1 pause sequence) into clean make/break key events.
- Tracks the held state of the six game keys.
- Produces single-cycle game command pulses, with software autorepeat on the movement keys.
- Keyboard typematic repeats are absorbed, so the game sees exactly one press edge per physical press.

Parameters:
- `REPEAT_DELAY`, 6250000: cycles from press to the first autorepeat pulse (250 ms at 25 MHz).
- `REPEAT_RATE`, 1250000: cycles between subsequent autorepeat pulses (50 ms).
- `PREFIX_TIMEOUT`, 2500000: cycles of FIFO silence after which a pending prefix is discarded (100 ms).
- `CNT_W`, 24: width of the repeat and timeout counters.

Ports:
- `clk` in 1: 25 MHz system clock.
- `rst` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: `ps2_if` `status[0]`; 1 = FIFO empty.
- `fifo_data` in 8: `ps2_if` `data[7:0]`; valid one cycle after a `fifo_rd` pulse.
- `fifo_rd` out 1: single-cycle FIFO pop.
- `key_valid` out 1: single-cycle key event strobe.
- `key_code` out 8: scan code of the event.
- `key_ext` out 1: event carried the E0 prefix.
- `key_make` out 1: 1 = press, 0 = release.
- `keys_held` out 6: held bitmap {pause, drop, rotate, down, right, left}.
- `cmd` out 6: single-cycle command pulses, same bit order as `keys_held`.

Behaviour:
- Reset (`rst` low, asynchronous): all outputs 0, FSM in IDLE, flags cleared, counters 0. Reset mid-sequence discards partial prefixes. A byte popped but not yet captured is lost, by design.
- Read FSM:
  - IDLE: if `fifo_empty`=0, assert `fifo_rd` for one cycle and go to WAIT.
  - WAIT: go to CAPTURE.
  - CAPTURE: register `fifo_data`, process the byte, return to IDLE.
  - Maximum rate is one byte per 3 cycles. `fifo_rd` is never asserted on two consecutive cycles.
- Byte processing, in priority order:
  - `skip_cnt`≠0: decrement it, no event.
  - E1: `skip_cnt`=7. The pause-key sequence is swallowed, with no event.
  - E0: `ext_flag`=1.
  - F0: `brk_flag`=1.
  - AA, FA, FE, EE, 00, FF: ignored, flags unchanged.
  - Otherwise: emit the event and clear both flags.
- Event emission: on the cycle after CAPTURE, `key_valid`=1, `key_code`=byte, `key_ext`=`ext_flag`, `key_make`=!`brk_flag`.
  - `key_code`, `key_ext` and `key_make` hold their values until the next event.
  - Event latency is 3 cycles from `fifo_rd` to `key_valid`.
- Prefix timeout: when `ext_flag`, `brk_flag` or `skip_cnt` is set, count idle cycles. At `PREFIX_TIMEOUT` clear all three. Any captured byte restarts the count.
- Key map (set 2):
  - E0 6B → left
  - E0 74 → right
  - E0 72 → down
  - E0 75 → rotate
  - 29 (space) → drop
  - 4D (P) → pause
  - The extended-ness must match: plain 6B (keypad 4) is not left.
- Held state: make sets the `keys_held` bit and break clears it; both update in the event cycle.
- Commands:
  - A make on a key whose held bit was 0 pulses its `cmd` bit in the event cycle.
  - A make on an already-held key (typematic repeat) produces no `cmd` pulse.
  - A break never pulses.
- Autorepeat, left/right/down only:
  - A single repeat counter tracks the most recently pressed of the three; a newer press retargets it and restarts it at 0.
  - After `REPEAT_DELAY` cycles held, pulse `cmd`, then pulse every `REPEAT_RATE` cycles.
  - Releasing the tracked key stops repeating. Other still-held movement keys do not resume repeating.
  - Rotate, drop and pause never autorepeat.
- Simultaneous events: a key-event pulse and an autorepeat pulse in the same cycle on different bits are both output. On the same bit the result is one pulse, and the counter restarts.
- Counter arithmetic is unsigned `CNT_W`-bit; counters saturate and never wrap.

Decomposition:
- Shared package `ps2_pkg` holds:
  - scan-code constants (`SC_E0`, `SC_F0`, `SC_E1`, `SC_LEFT`, `SC_RIGHT`, `SC_DOWN`, `SC_UP`, `SC_SPACE`, `SC_P`, ignore codes);
  - command bit indices (`CMD_LEFT`..`CMD_PAUSE`);
  - the FSM state encoding.
- One sub-module, `key_repeat`, contains the repeat counter, target select and pulse generation. The parent holds the FIFO FSM, the prefix parser and the key map.

Test Plan:
Benches run with `REPEAT_DELAY`=20, `REPEAT_RATE`=5, `PREFIX_TIMEOUT`=50.
1. Bytes E0,6B,E0,F0,6B → `key_valid` twice: (6B, ext=1, make=1), then (6B, ext=1, make=0). `cmd[0]` pulses once; `keys_held[0]` goes 1 then 0.
2. Bytes 29,29,29,F0,29 → exactly one `cmd[4]` pulse, four `key_valid` strobes, `keys_held[4]` cleared at the end.
3. E0 74 held 40 cycles, then released → `cmd[1]` pulses at the press, at +20, +25, +30 and +35; none after the break.
4. E1,14,77,E1,F0,14,F0,77, then 4D → no events for the 8-byte sequence; one event (4D, make) and a `cmd[5]` pulse.
5. E0, then 60 idle cycles, then 6B → event (6B, ext=0), no `cmd[0]`.
6. `rst` low after E0,F0, then released, then 72 → event (72, ext=0, make=1). During reset all outputs are 0 and `fifo_rd` is 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan codes, game command bit indices and the FIFO read FSM encoding.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam int CMD_LEFT   = 0;
  localparam int CMD_RIGHT  = 1;
  localparam int CMD_DOWN   = 2;
  localparam int CMD_ROTATE = 3;
  localparam int CMD_DROP   = 4;
  localparam int CMD_PAUSE  = 5;

  // Only the movement keys take part in autorepeat.
  localparam logic [5:0] MOVE_MASK = 6'b000111;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_WAIT    = 2'd1,
    RD_CAPTURE = 2'd2
  } rd_state_e;

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic is_ignore(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

  // One-hot game key for a scan code; the E0 prefix must match exactly.
  function automatic logic [5:0] key_map(input logic [7:0] b, input logic ext);
    logic [5:0] m;
    m = '0;
    if (ext) begin
      case (b)
        SC_LEFT:  m[CMD_LEFT]   = 1'b1;
        SC_RIGHT: m[CMD_RIGHT]  = 1'b1;
        SC_DOWN:  m[CMD_DOWN]   = 1'b1;
        SC_UP:    m[CMD_ROTATE] = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (b)
        SC_SPACE: m[CMD_DROP]  = 1'b1;
        SC_P:     m[CMD_PAUSE] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Press-edge command pulses plus single-target software autorepeat for the movement keys.
module key_repeat
  import ps2_pkg::*;
#(
  parameter int REPEAT_DELAY = 6250000,
  parameter int REPEAT_RATE  = 1250000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev,
  input  logic       ev_make,
  input  logic [5:0] ev_hit,
  input  logic [5:0] held,
  output logic [5:0] cmd
);

  localparam logic [CNT_W-1:0] DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RTE = CNT_W'(REPEAT_RATE);

  logic [5:0]       trk;
  logic             first;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [5:0]       press_vec, mv_press;
  logic             brk_trk, fire;

  // Typematic makes on an already-held key are not press edges.
  assign press_vec = (ev && ev_make) ? (ev_hit & ~held) : '0;
  assign mv_press  = press_vec & MOVE_MASK;
  assign brk_trk   = ev && !ev_make && |(ev_hit & trk);
  assign cnt_n     = (cnt == '1) ? cnt : cnt + 1'b1;
  assign fire      = |trk && (cnt_n == (first ? DLY : RTE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd   <= '0;
      trk   <= '0;
      first <= 1'b0;
      cnt   <= '0;
    end else begin
      cmd <= press_vec | ((fire && !brk_trk) ? trk : '0);
      if (|mv_press) begin
        trk   <= mv_press;
        first <= 1'b1;
        cnt   <= '0;
      end else if (brk_trk) begin
        trk <= '0;
        cnt <= '0;
      end else if (|trk) begin
        if (fire) begin
          first <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt_n;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Drains the ps2_if byte FIFO, strips set-2 prefixes into make/break events and drives game commands.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int REPEAT_DELAY   = 6250000,
  parameter int REPEAT_RATE    = 1250000,
  parameter int PREFIX_TIMEOUT = 2500000,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic [5:0] keys_held,
  output logic [5:0] cmd
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  rd_state_e        state, state_nxt;
  logic             capture;
  logic             ext_flag, brk_flag;
  logic [2:0]       skip_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             pending, is_ign, ev;
  logic [5:0]       ev_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RD_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:    if (!fifo_empty) state_nxt = RD_WAIT;
      RD_WAIT:    state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = RD_IDLE;
      default:    state_nxt = RD_IDLE;
    endcase
  end

  // fifo_rd is gated by reset so no pop escapes while the block is held in reset.
  always_comb begin
    fifo_rd = 1'b0;
    capture = 1'b0;
    case (state)
      RD_IDLE:    fifo_rd = rst & ~fifo_empty;
      RD_CAPTURE: capture = 1'b1;
      default:    ;
    endcase
  end

  assign is_ign  = is_ignore(fifo_data);
  assign pending = ext_flag | brk_flag | (skip_cnt != 3'd0);
  assign ev      = capture && (skip_cnt == 3'd0) && (fifo_data != SC_E1) &&
                   (fifo_data != SC_E0) && (fifo_data != SC_F0) && !is_ign;
  assign ev_hit  = ev ? key_map(fifo_data, ext_flag) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_make  <= 1'b0;
      keys_held <= '0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      skip_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      key_valid <= ev;
      if (ev) begin
        key_code  <= fifo_data;
        key_ext   <= ext_flag;
        key_make  <= !brk_flag;
        keys_held <= brk_flag ? (keys_held & ~ev_hit) : (keys_held | ev_hit);
      end
      if (capture) begin
        tmo_cnt <= '0;
        if (skip_cnt != 3'd0)      skip_cnt <= skip_cnt - 3'd1;
        else if (fifo_data == SC_E1) skip_cnt <= 3'd7;
        else if (fifo_data == SC_E0) ext_flag <= 1'b1;
        else if (fifo_data == SC_F0) brk_flag <= 1'b1;
        else if (!is_ign) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end else if (pending) begin
        // A stale prefix (e.g. a lost byte) must not corrupt the next key.
        if (tmo_cnt >= TMO_LAST) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          skip_cnt <= '0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) u_repeat (
    .clk    (clk),
    .rst    (rst),
    .ev     (ev),
    .ev_make(!brk_flag),
    .ev_hit (ev_hit),
    .held   (keys_held),
    .cmd    (cmd)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with an event-level reference model checked every cycle.
module tb_ps2_key_decoder;

  localparam int DELAY = 20;
  localparam int RATE  = 5;
  localparam int PTMO  = 50;

  typedef struct { int due; logic [7:0] b; } pipe_t;
  typedef struct packed { logic [7:0] code; logic ext; logic make; } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, key_valid, key_code_ext, key_make;
  logic [7:0] key_code;
  logic [5:0] keys_held, cmd;

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [7:0] fifo_q[$];
  pipe_t      pipe[$];
  ev_t        ev_q[$];
  int         pulse_q[$];
  int         cmd_cnt[6];

  // reference model state
  int         cyc = 0, ncyc = 0, last_cap = 0, press_cyc = 0, trk = -1, skip = 0;
  logic       ext_f = 0, brk_f = 0, prev_rd = 0;
  logic       m_valid = 0, m_ext = 0, m_make = 0;
  logic [7:0] m_code = 0;
  logic [5:0] m_held = 0, m_cmd = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .PREFIX_TIMEOUT(PTMO), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_code_ext), .key_make(key_make), .keys_held(keys_held), .cmd(cmd)
  );

  function automatic int key_idx(input logic [7:0] b, input logic ext);
    if (ext && b == 8'h6B) return 0;
    if (ext && b == 8'h74) return 1;
    if (ext && b == 8'h72) return 2;
    if (ext && b == 8'h75) return 3;
    if (!ext && b == 8'h29) return 4;
    if (!ext && b == 8'h4D) return 5;
    return -1;
  endfunction

  function automatic logic is_ign(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Event-level model: a popped byte is parsed two edges later; repeats are timed from the press.
  task automatic model_step();
    pipe_t pe;
    logic [7:0] b;
    logic [5:0] rep;
    int k, d;
    if (!rst) begin
      m_valid = 0; m_code = 0; m_ext = 0; m_make = 0; m_held = 0; m_cmd = 0;
      ext_f = 0; brk_f = 0; skip = 0; trk = -1;
      pipe.delete();
      fifo_empty <= (fifo_q.size() == 0);
      return;
    end
    m_valid = 0;
    m_cmd = 0;
    rep = 0;
    if (trk >= 0) begin
      d = cyc - press_cyc;
      if (d == DELAY || (d > DELAY && (d - DELAY) % RATE == 0)) rep[trk] = 1'b1;
    end
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      pe = pipe.pop_front();
      b = pe.b;
      last_cap = cyc;
      if (skip > 0) skip--;
      else if (b == 8'hE1) skip = 7;
      else if (b == 8'hE0) ext_f = 1;
      else if (b == 8'hF0) brk_f = 1;
      else if (!is_ign(b)) begin
        m_valid = 1; m_code = b; m_ext = ext_f; m_make = !brk_f;
        k = key_idx(b, ext_f);
        if (k >= 0) begin
          if (!brk_f) begin
            if (!m_held[k]) begin
              m_cmd[k] = 1'b1;
              if (k <= 2) begin trk = k; press_cyc = cyc; end
            end
            m_held[k] = 1'b1;
          end else begin
            m_held[k] = 1'b0;
            if (k == trk) begin trk = -1; rep = 0; end
          end
        end
        ext_f = 0; brk_f = 0;
      end
    end else if ((ext_f || brk_f || skip > 0) && (cyc - last_cap >= PTMO)) begin
      ext_f = 0; brk_f = 0; skip = 0;
    end
    m_cmd = m_cmd | rep;
    if (fifo_rd) begin
      if (fifo_q.size() == 0) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL fifo_underflow: got fifo_rd=1 expected 0 while empty, cycle %0d", cyc);
      end else begin
        b = fifo_q.pop_front();
        fifo_data <= b;
        pe.due = cyc + 2;
        pe.b = b;
        pipe.push_back(pe);
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic mon_step();
    logic bad;
    ev_t e;
    ncyc++;
    vec_cnt++;
    bad = (key_valid !== m_valid) || (keys_held !== m_held) || (cmd !== m_cmd) ||
          (key_code !== m_code) || (key_code_ext !== m_ext) || (key_make !== m_make);
    if (bad) begin
      miss_cnt++;
      if (miss_cnt <= 30)
        $display("FAIL outputs cycle %0d: got v=%0b code=%02h ext=%0b make=%0b held=%06b cmd=%06b, expected v=%0b code=%02h ext=%0b make=%0b held=%06b cmd=%06b",
                 ncyc, key_valid, key_code, key_code_ext, key_make, keys_held, cmd,
                 m_valid, m_code, m_ext, m_make, m_held, m_cmd);
    end
    vec_cnt++;
    if ((fifo_rd === 1'b1 && prev_rd) || (!rst && fifo_rd !== 1'b0)) begin
      miss_cnt++;
      $display("FAIL fifo_rd cycle %0d: got %0b (prev %0b, rst %0b) expected single pulse, none in reset",
               ncyc, fifo_rd, prev_rd, rst);
    end
    prev_rd = fifo_rd;
    if (key_valid) begin
      e.code = key_code; e.ext = key_code_ext; e.make = key_make;
      ev_q.push_back(e);
    end
    for (int i = 0; i < 6; i++) if (cmd[i]) cmd_cnt[i]++;
    if (cmd[1]) pulse_q.push_back(ncyc);
  endtask

  always @(posedge clk or negedge rst) model_step();
  always @(negedge clk) mon_step();

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic clear_logs();
    ev_q.delete();
    pulse_q.delete();
    for (int i = 0; i < 6; i++) cmd_cnt[i] = 0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({nm, "_drain_timeout"}, n, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_ev(input string nm, input int idx, input logic [7:0] code,
                        input logic ext, input logic make);
    ev_t exp_e, got_e;
    exp_e.code = code; exp_e.ext = ext; exp_e.make = make;
    got_e = (idx < ev_q.size()) ? ev_q[idx] : '1;
    chk(nm, int'(got_e), int'(exp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_held", int'(keys_held), 0);
    chk("reset_valid", int'(key_valid), 0);

    // 1: extended left press then release
    clear_logs();
    send(8'hE0); send(8'h6B);
    drain("t1a");
    chk("t1_held_after_make", int'(keys_held[0]), 1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    drain("t1b");
    chk("t1_ev_count", ev_q.size(), 2);
    chk_ev("t1_ev0", 0, 8'h6B, 1'b1, 1'b1);
    chk_ev("t1_ev1", 1, 8'h6B, 1'b1, 1'b0);
    chk("t1_cmd0_pulses", cmd_cnt[0], 1);
    chk("t1_held_after_break", int'(keys_held[0]), 0);
    chk("t1_model_held", int'(m_held), 0);

    // 2: typematic space absorbed
    clear_logs();
    send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29);
    drain("t2");
    chk("t2_ev_count", ev_q.size(), 4);
    chk("t2_cmd4_pulses", cmd_cnt[4], 1);
    chk("t2_held4", int'(keys_held[4]), 0);
    chk_ev("t2_ev3", 3, 8'h29, 1'b0, 1'b0);

    // 3: right held ~37 cycles with autorepeat
    clear_logs();
    send(8'hE0); send(8'h74);
    p = 0;
    while (!key_valid && p < 60) begin
      @(negedge clk);
      p++;
    end
    chk("t3_press_seen", int'(key_valid), 1);
    repeat (27) @(negedge clk);
    send(8'hE0); send(8'hF0); send(8'h74);
    repeat (60) @(negedge clk);
    chk("t3_cmd1_pulses", cmd_cnt[1], 5);
    chk("t3_off1", (pulse_q.size() > 1) ? pulse_q[1] - pulse_q[0] : -1, 20);
    chk("t3_off2", (pulse_q.size() > 2) ? pulse_q[2] - pulse_q[0] : -1, 25);
    chk("t3_off3", (pulse_q.size() > 3) ? pulse_q[3] - pulse_q[0] : -1, 30);
    chk("t3_off4", (pulse_q.size() > 4) ? pulse_q[4] - pulse_q[0] : -1, 35);
    chk("t3_held1", int'(keys_held[1]), 0);

    // 4: pause sequence swallowed, then P
    clear_logs();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h4D);
    drain("t4");
    chk("t4_ev_count", ev_q.size(), 1);
    chk_ev("t4_ev0", 0, 8'h4D, 1'b0, 1'b1);
    chk("t4_cmd5_pulses", cmd_cnt[5], 1);
    chk("t4_model_held", int'(m_held), 6'b100000);
    send(8'hF0); send(8'h4D);
    drain("t4r");

    // 5: stale E0 times out, plain 6B is keypad 4
    clear_logs();
    send(8'hE0);
    drain("t5a");
    repeat (60) @(negedge clk);
    send(8'h6B);
    drain("t5b");
    chk("t5_ev_count", ev_q.size(), 1);
    chk_ev("t5_ev0", 0, 8'h6B, 1'b0, 1'b1);
    chk("t5_cmd0_pulses", cmd_cnt[0], 0);

    // 6: reset discards pending E0 F0; a byte waiting in reset is not popped
    clear_logs();
    send(8'hE0); send(8'hF0);
    drain("t6a");
    #2 rst = 1'b0;
    send(8'h72);
    repeat (4) @(negedge clk);
    chk("t6_rd_in_reset", int'(fifo_rd), 0);
    chk("t6_cmd_in_reset", int'(cmd), 0);
    #2 rst = 1'b1;
    drain("t6b");
    chk("t6_ev_count", ev_q.size(), 1);
    chk_ev("t6_ev0", 0, 8'h72, 1'b0, 1'b1);
    chk("t6_cmd2_pulses", cmd_cnt[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
